lcd_stream_controller: RTL and testbench
========================================

Name: lcd_stream_controller

Overview:
Parametrised successor to the LCD_Controller. Generates LCD timing for a configurable panel, pulls RGB565 pixels from the camera FIFO and resynchronises on start-of-frame marker words. Adds a built-in test-pattern mode and underflow/desync accounting. It sits between the FIFO_cam read side and the LCD pins, and is clocked on the screen/framebuffer clock.

Parameters:
H_ACTIVE, 480, active pixels per line
H_FP, 8, horizontal front porch (clocks)
H_SYNC, 4, HSYNC width (clocks)
H_BP, 43, horizontal back porch (clocks)
V_ACTIVE, 272, active lines per frame
V_FP, 8, vertical front porch (lines)
V_SYNC, 4, VSYNC width (lines)
V_BP, 12, vertical back porch (lines)
SYNC_ACTIVE_LOW, 1, 1 = HSYNC/VSYNC asserted low
CNT_WIDTH, 16, width of underflow_cnt

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
mode  in  2  0 = queue stream, 1 = colour bars, 2 = solid fill_color, 3 = reserved (behaves as 2)
fill_color  in  16  RGB565 colour for fill, underflow and mode 2
queue_data_in  in  17  FIFO Q: bit16 = SOF marker, [15:0] = RGB565
queue_empty  in  1  FIFO empty
queue_rd_en  out  1  FIFO read enable
queue_clk  out  1  FIFO read clock, equal to clk
LCD_DE  out  1  data enable
LCD_HSYNC  out  1  horizontal sync
LCD_VSYNC  out  1  vertical sync
LCD_R  out  5  red, fill/pixel [15:11]
LCD_G  out  6  green, fill/pixel [10:5]
LCD_B  out  5  blue, fill/pixel [4:0]
frame_start  out  1  one-clock pulse aligned with the first DE of each frame
underflow  out  1  sticky flag; cleared only by reset
desync  out  1  sticky flag; early or late SOF seen
underflow_cnt  out  CNT_WIDTH  saturating count of underflowed pixels

Behaviour:
- Reset values: all outputs 0 except HSYNC/VSYNC, which take their deasserted level. Counters reset to 0. State resets to SEEK.
- Timing: hcnt runs 0..H_TOTAL-1 and vcnt runs 0..V_TOTAL-1 (TOTAL = ACTIVE+FP+SYNC+BP). Counters are free-running in every state and mode.
- Region order per axis: active, FP, SYNC, BP. active = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
- Pipeline: S0 = counter position. S1 = FIFO data valid (one-clock registered read). S2 = registered pins. DE, HSYNC, VSYNC and frame_start are delayed 2 clocks so they align with pixel data.
- mode is sampled only at hcnt=0, vcnt=0. A mid-frame change takes effect at the next frame.
- Queue-mode states:
  - SEEK: rd_en whenever !queue_empty. Non-marker words are discarded. A marker moves to ARMED. Active pixels show fill_color. No underflow counting.
  - ARMED: no reads. At S0 position (0,0) move to STREAM.
  - STREAM: at each active S0 with !queue_empty, assert rd_en.
    - At S1 the word is a pixel: output it.
    - At S1 the word is a marker (early SOF): set desync, output fill_color, suppress reads for the rest of the frame, go to ARMED.
    - If an active S0 sees queue_empty: no read, output fill_color at S2, set underflow, underflow_cnt+1 (saturates at all-ones).
  - After the last active pixel of a STREAM frame, go to SEEK.
    - Non-marker words popped in SEEK before the next marker set desync (late SOF).
    - Words popped in SEEK never count as underflow.
- queue_rd_en is never asserted while queue_empty=1.
- Mode 1: 8 equal bars. Index = (hcnt*8)/H_ACTIVE, colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Modes 1 and 2: the queue is drained continuously (rd_en = !queue_empty), data is ignored, state is forced to SEEK, no flags update.
- Blanking: RGB = 0 whenever DE = 0.
- Asynchronous reset mid-frame clears all state immediately. Pins return to their reset values on the same edge.

Test Plan:
1. H_ACTIVE=23, V_ACTIVE=17, porches 2/2/2, mode 0. Queue 17'h10000 then 391 words of 16'hF800 → frame_start once; 391 DE clocks, all R=31/G=0/B=0; underflow=0, desync=0.
2. Same params. SOF plus only 100 pixels → pixels 0..99 red, 101st..391st = fill_color (16'h001F); underflow=1, underflow_cnt=291.
3. SOF, 50 pixels, SOF, 391 pixels → desync=1; frame 1 shows 50 pixels then fill; frame 2 is fully correct.
4. mode=1, 5 words queued → all 5 popped, ignored; line 0 bars at hcnt 0,3,6,9,12,15,18,21 = FFFF..0000; underflow stays 0.
5. Check sync timing: HSYNC low exactly H_SYNC clocks each line; VSYNC low for V_SYNC×H_TOTAL clocks; DE-to-pixel alignment exact.
6. Assert reset_n low mid-STREAM, release → all pins at reset values immediately; state SEEK; the next frame requires a fresh SOF.

Source files
------------

// File: rtl/lcd_stream_controller.sv
// LCD timing generator that streams RGB565 pixels from the camera FIFO, locks
// onto start-of-frame marker words and offers colour-bar / solid-fill modes.
module lcd_stream_controller #(
    parameter int H_ACTIVE        = 480,
    parameter int H_FP            = 8,
    parameter int H_SYNC          = 4,
    parameter int H_BP            = 43,
    parameter int V_ACTIVE        = 272,
    parameter int V_FP            = 8,
    parameter int V_SYNC          = 4,
    parameter int V_BP            = 12,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           mode,
    input  logic [15:0]          fill_color,
    input  logic [16:0]          queue_data_in,
    input  logic                 queue_empty,
    output logic                 queue_rd_en,
    output logic                 queue_clk,
    output logic                 LCD_DE,
    output logic                 LCD_HSYNC,
    output logic                 LCD_VSYNC,
    output logic [4:0]           LCD_R,
    output logic [5:0]           LCD_G,
    output logic [4:0]           LCD_B,
    output logic                 frame_start,
    output logic                 underflow,
    output logic                 desync,
    output logic [CNT_WIDTH-1:0] underflow_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_M1 = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_M1 = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          SYNC_OFF = (SYNC_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {SEEK, ARMED, STREAM} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hcnt;
    logic [VW-1:0]   vcnt;
    logic [1:0]      frame_mode;
    logic            run_q;
    logic            late_q, late_d;

    logic            s1_active, s1_hs, s1_vs, s1_fs, s1_stream, s1_seek;
    logic [1:0]      s1_mode;
    logic [2:0]      s1_bar;

    logic            at_origin, s0_active, last_px, hs_on, vs_on;
    logic [1:0]      cur_mode;
    logic            queue_mode, s1_marker;
    logic [2:0]      bar_idx;
    logic            stream_slot, stream_rd, seek_rd, desync_set, uf_hit;
    logic [15:0]     pix;

    assign queue_clk = clk;

    // S0: free-running raster position
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!reset_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    assign at_origin  = (hcnt == '0) && (vcnt == '0);
    assign s0_active  = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign last_px    = (hcnt == H_ACT_M1) && (vcnt == V_ACT_M1);
    assign hs_on      = (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign vs_on      = (vcnt >= VS_BEG) && (vcnt < VS_END);
    assign cur_mode   = at_origin ? mode : frame_mode;
    assign queue_mode = (cur_mode == 2'd0);
    assign s1_marker  = (s1_stream || s1_seek) && queue_data_in[16];
    assign bar_idx    = 3'((32'(hcnt) * 32'd8) / 32'(H_ACTIVE));

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a value held and infer a latch.
        state_d     = state_q;
        late_d      = late_q;
        queue_rd_en = 1'b0;
        stream_slot = 1'b0;
        seek_rd     = 1'b0;
        desync_set  = 1'b0;
        if (!queue_mode) begin
            state_d     = SEEK;
            late_d      = 1'b0;
            queue_rd_en = run_q && !queue_empty;
        end else begin
            case (state_q)
                SEEK: begin
                    if (s1_marker) begin
                        state_d = ARMED;
                        late_d  = 1'b0;
                    end else begin
                        seek_rd = run_q && !queue_empty;
                        if (s1_seek && late_q) desync_set = 1'b1;
                    end
                end
                ARMED: begin
                    if (at_origin) begin
                        state_d     = STREAM;
                        stream_slot = s0_active;
                    end
                end
                STREAM: begin
                    stream_slot = s0_active && !s1_marker;
                    if (last_px) begin
                        state_d = SEEK;
                        late_d  = 1'b1;
                    end
                end
                default: state_d = SEEK;
            endcase
            // A marker arriving in a pixel slot means the source restarted early
            if (s1_stream && queue_data_in[16]) begin
                desync_set  = 1'b1;
                state_d     = ARMED;
                late_d      = 1'b0;
                stream_slot = 1'b0;
            end
            queue_rd_en = seek_rd || (stream_slot && !queue_empty);
        end
        stream_rd = stream_slot && !queue_empty;
        uf_hit    = stream_slot && queue_empty;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SEEK;
            late_q     <= 1'b0;
            frame_mode <= 2'd0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            late_q     <= late_d;
            frame_mode <= cur_mode;
            run_q      <= 1'b1;
        end
    end

    // S1: position-derived controls travel alongside the FIFO read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_active <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_fs     <= 1'b0;
            s1_stream <= 1'b0;
            s1_seek   <= 1'b0;
            s1_mode   <= 2'd0;
            s1_bar    <= 3'd0;
        end else begin
            s1_active <= s0_active;
            s1_hs     <= hs_on;
            s1_vs     <= vs_on;
            s1_fs     <= at_origin;
            s1_stream <= stream_rd;
            s1_seek   <= seek_rd;
            s1_mode   <= cur_mode;
            s1_bar    <= bar_idx;
        end
    end

    always_comb begin
        pix = fill_color;
        if (s1_mode == 2'd1)
            pix = bar_color(s1_bar);
        else if (s1_mode == 2'd0 && s1_stream && !queue_data_in[16])
            pix = queue_data_in[15:0];
    end

    // S2: registered pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            LCD_DE      <= 1'b0;
            LCD_HSYNC   <= SYNC_OFF;
            LCD_VSYNC   <= SYNC_OFF;
            {LCD_R, LCD_G, LCD_B} <= 16'h0000;
            frame_start <= 1'b0;
        end else begin
            LCD_DE      <= s1_active;
            LCD_HSYNC   <= s1_hs ^ SYNC_OFF;
            LCD_VSYNC   <= s1_vs ^ SYNC_OFF;
            {LCD_R, LCD_G, LCD_B} <= s1_active ? pix : 16'h0000;
            frame_start <= s1_fs;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underflow     <= 1'b0;
            desync        <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            if (desync_set) desync <= 1'b1;
            if (uf_hit) begin
                underflow <= 1'b1;
                if (underflow_cnt != '1) underflow_cnt <= underflow_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_lcd_stream_controller.sv
// Directed bench for lcd_stream_controller on a 23x17 panel with 2/2/2 porches,
// fed by a small registered-read FIFO model.
module tb_lcd_stream_controller;

    localparam int H_TOT = 29;
    localparam int V_TOT = 23;
    localparam int FRAME = H_TOT * V_TOT;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  mode;
    logic [15:0] fill_color;
    logic [16:0] queue_data_in = 17'h0;
    logic        queue_empty;
    logic        queue_rd_en, queue_clk;
    logic        LCD_DE, LCD_HSYNC, LCD_VSYNC;
    logic [4:0]  LCD_R, LCD_B;
    logic [5:0]  LCD_G;
    logic        frame_start, underflow, desync;
    logic [15:0] underflow_cnt;

    logic [16:0] mem [4096];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          cyc = 0;
    int          bad_rd = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic [15:0] bar_tab [8];

    lcd_stream_controller #(
        .H_ACTIVE(23), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(17), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_ACTIVE_LOW(1), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .fill_color(fill_color),
        .queue_data_in(queue_data_in), .queue_empty(queue_empty),
        .queue_rd_en(queue_rd_en), .queue_clk(queue_clk),
        .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC),
        .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
        .frame_start(frame_start), .underflow(underflow), .desync(desync),
        .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    assign queue_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (queue_rd_en && queue_empty) bad_rd++;
        if (queue_rd_en && !queue_empty) begin
            queue_data_in <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Clocks since reset release; pins at cycle c show raster position c-2
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [16:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic push_pixels(input int n, input logic [15:0] c);
        for (int i = 0; i < n; i++) push({1'b0, c});
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
        if (cyc != n) chk("schedule", cyc, n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Compares every pin of one frame against an independent raster model
    task automatic scan_frame(input string tag, input int f, input bit bars, input int n_a,
                              input logic [15:0] col_a, input logic [15:0] col_b);
        int de_n, fs_n, vs_n, de_e, hs_e, vs_e, fs_e, px_e;
        de_n = 0; fs_n = 0; vs_n = 0; de_e = 0; hs_e = 0; vs_e = 0; fs_e = 0; px_e = 0;
        for (int c = 0; c < FRAME; c++) begin
            int h, v, k;
            logic e_de, e_hs, e_vs, e_fs;
            logic [15:0] e_px;
            wait_cyc(2 + f * FRAME + c);
            h = c % H_TOT;
            v = c / H_TOT;
            k = v * 23 + h;
            e_de = (h < 23) && (v < 17);
            e_hs = (h >= 25) && (h < 27);
            e_vs = (v >= 19) && (v < 21);
            e_fs = (h == 0) && (v == 0);
            if (!e_de)     e_px = 16'h0000;
            else if (bars) e_px = bar_tab[(h * 8) / 23];
            else           e_px = (k < n_a) ? col_a : col_b;
            if (LCD_DE) de_n++;
            if (frame_start) fs_n++;
            if (LCD_VSYNC === 1'b0) vs_n++;
            if (LCD_DE !== e_de) de_e++;
            if (LCD_HSYNC !== !e_hs) hs_e++;
            if (LCD_VSYNC !== !e_vs) vs_e++;
            if (frame_start !== e_fs) fs_e++;
            if ({LCD_R, LCD_G, LCD_B} !== e_px) px_e++;
        end
        chk({tag, " de_count"}, de_n, 391);
        chk({tag, " de_timing_errs"}, de_e, 0);
        chk({tag, " hsync_errs"}, hs_e, 0);
        chk({tag, " vsync_low_clocks"}, vs_n, 2 * H_TOT);
        chk({tag, " vsync_errs"}, vs_e, 0);
        chk({tag, " frame_start_count"}, fs_n, 1);
        chk({tag, " frame_start_errs"}, fs_e, 0);
        chk({tag, " pixel_errs"}, px_e, 0);
    endtask

    initial begin
        bar_tab = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                    16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        reset_n    = 1'b0;
        mode       = 2'd0;
        fill_color = 16'h001F;
        #23;

        // Reset values
        chk("rst DE", LCD_DE, 0);
        chk("rst RGB", {LCD_R, LCD_G, LCD_B}, 0);
        chk("rst HSYNC", LCD_HSYNC, 1);
        chk("rst VSYNC", LCD_VSYNC, 1);
        chk("rst frame_start", frame_start, 0);
        chk("rst rd_en", queue_rd_en, 0);
        chk("rst flags", {underflow, desync}, 0);
        chk("rst underflow_cnt", underflow_cnt, 0);
        chk("queue_clk", queue_clk, clk);

        // Test 1: SOF then one full frame of red
        @(negedge clk);
        reset_n = 1'b1;
        push(17'h10000);
        push_pixels(391, 16'hF800);
        scan_frame("t1 f0", 0, 1'b0, 0, 16'h001F, 16'h001F);
        scan_frame("t1 f1", 1, 1'b0, 391, 16'hF800, 16'h001F);
        chk("t1 R", LCD_R, 0);
        chk("t1 underflow", underflow, 0);
        chk("t1 desync", desync, 0);
        chk("t1 underflow_cnt", underflow_cnt, 0);

        // Test 2: SOF with only 100 pixels
        do_reset();
        push(17'h10000);
        push_pixels(100, 16'hF800);
        scan_frame("t2 f1", 1, 1'b0, 100, 16'hF800, 16'h001F);
        chk("t2 underflow", underflow, 1);
        chk("t2 underflow_cnt", underflow_cnt, 291);
        chk("t2 desync", desync, 0);
        wait_cyc(2 + 3 * FRAME);
        chk("t2 underflow_cnt held", underflow_cnt, 291);

        // Test 3: early SOF after 50 pixels, then a clean frame
        do_reset();
        push(17'h10000);
        push_pixels(50, 16'hF800);
        push(17'h10000);
        push_pixels(391, 16'h07E0);
        scan_frame("t3 f1", 1, 1'b0, 50, 16'hF800, 16'h001F);
        scan_frame("t3 f2", 2, 1'b0, 391, 16'h07E0, 16'h001F);
        chk("t3 desync", desync, 1);
        chk("t3 underflow", underflow, 0);

        // Test 4: colour bars drain the queue; mid-frame mode change waits a frame
        @(negedge clk);
        reset_n = 1'b0;
        mode = 2'd1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        push(17'h10000);
        push_pixels(4, 16'h1234);
        wait_cyc(1);
        mode = 2'd2;
        scan_frame("t4 bars", 0, 1'b1, 0, 16'h0000, 16'h0000);
        scan_frame("t4 fill", 1, 1'b0, 0, 16'h001F, 16'h001F);
        chk("t4 drained", rd_ptr, wr_ptr);
        chk("t4 underflow", underflow, 0);
        chk("t4 desync", desync, 0);
        mode = 2'd0;

        // Test 6: asynchronous reset mid-stream
        do_reset();
        push(17'h10000);
        push_pixels(391, 16'hF800);
        wait_cyc(2 + FRAME + 7 * H_TOT);
        chk("t6 pre DE", LCD_DE, 1);
        chk("t6 pre RGB", {LCD_R, LCD_G, LCD_B}, 16'hF800);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6 rst DE", LCD_DE, 0);
        chk("t6 rst RGB", {LCD_R, LCD_G, LCD_B}, 0);
        chk("t6 rst syncs", {LCD_HSYNC, LCD_VSYNC}, 2'b11);
        chk("t6 rst frame_start", frame_start, 0);
        chk("t6 rst rd_en", queue_rd_en, 0);
        @(negedge clk);
        reset_n = 1'b1;
        scan_frame("t6 f0", 0, 1'b0, 0, 16'h001F, 16'h001F);
        push(17'h10000);
        push_pixels(391, 16'h07E0);
        scan_frame("t6 f1", 1, 1'b0, 0, 16'h001F, 16'h001F);
        scan_frame("t6 f2", 2, 1'b0, 391, 16'h07E0, 16'h001F);
        chk("t6 desync", desync, 0);
        chk("t6 underflow", underflow, 0);

        chk("rd_while_empty", bad_rd, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
